// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the 4-digit seven-segment scan driver.
// Holds the scan FSM state type, the active-low glyph table
// ({g,f,e,d,c,b,a}, 0 = segment lit) and the all-off blank pattern.
package seg7_scan_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index = nibble value; entries 10-15 are the hex glyphs A b C d E F.
    localparam logic [6:0] GLYPH_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when exactly one bit is set; all-zero is not one-hot.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Nibble to active-low seven-segment decoder (combinational, zero latency).
// Ports: nibble_i value, blank_i forces all segments off, seg_o {g,f,e,d,c,b,a}.
// Values above 9 decode to hex glyphs only when HEX_MODE is set, else blank.
module seg7_decode
    import seg7_scan_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (HEX_MODE || (nibble_i <= 4'd9))) begin
            seg_o = GLYPH_TAB[nibble_i];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver slaved to an external one-hot ring.
// Ports: clock/reset (sync, active-high), ring_in select, digits_in/dp_in/load
// staging write, load_ack, registered an/seg/dp_n (active-low), err/err_count.
module seg7_scan_driver
    import seg7_scan_pkg::*;
#(
    parameter bit LZ_BLANK = 1'b1,
    parameter bit HEX_MODE = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  ring_in,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        err,
    output logic [7:0]  err_count
);

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [15:0] stage_dig_q, stage_dig_d;
    logic [3:0]  stage_dp_q, stage_dp_d;
    logic [15:0] shadow_dig_q, shadow_dig_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_n_q, dp_n_d;
    logic        load_ack_q, load_ack_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        ring_ok;
    logic        sync_hit;
    logic        xfer;
    logic        show;
    logic [1:0]  sel_idx;
    logic [3:0]  blank_vec;
    logic [3:0]  sel_nib;
    logic [6:0]  dec_seg;

    assign ring_ok  = is_onehot(ring_in);
    assign sync_hit = (ring_in == 4'b0001);

    // Frame-boundary handoff: new digits only ever enter the shadow at the
    // start of digit0, so a frame is never a mix of old and new data.
    assign xfer = pending_q && (state_q != ST_FAULT) && sync_hit;

    always_comb begin
        sel_idx = 2'd0;
        case (ring_in)
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:  if (sync_hit) state_d = ST_RUN;
            ST_RUN:   if (!ring_ok) state_d = ST_FAULT;
            ST_FAULT: if (sync_hit) state_d = ST_SYNC;
            default:  state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        shadow_dig_d = xfer ? stage_dig_q : shadow_dig_q;
        shadow_dp_d  = xfer ? stage_dp_q  : shadow_dp_q;
        stage_dig_d  = load ? digits_in   : stage_dig_q;
        stage_dp_d   = load ? dp_in       : stage_dp_q;
        // A load in the transfer cycle re-arms pending for the next frame.
        pending_d    = load | (pending_q & ~xfer);
        load_ack_d   = xfer;
    end

    // Blanking looks at the post-transfer shadow so the digit0 shown in the
    // transfer cycle already belongs to the new frame.
    always_comb begin
        blank_vec[0] = 1'b0;
        blank_vec[3] = LZ_BLANK && (shadow_dig_d[15:12] == 4'd0);
        blank_vec[2] = blank_vec[3] && (shadow_dig_d[11:8] == 4'd0);
        blank_vec[1] = blank_vec[2] && (shadow_dig_d[7:4] == 4'd0);
    end

    assign sel_nib = shadow_dig_d[{sel_idx, 2'b00} +: 4];

    seg7_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_decode (
        .nibble_i (sel_nib),
        .blank_i  (blank_vec[sel_idx]),
        .seg_o    (dec_seg)
    );

    // Entering or staying in RUN implies ring_in is one-hot this cycle.
    assign show = (state_d == ST_RUN);

    always_comb begin
        an_d      = show ? ~ring_in : 4'hF;
        seg_d     = show ? dec_seg : SEG_BLANK;
        dp_n_d    = show ? ~shadow_dp_d[sel_idx] : 1'b1;
        err_d     = err_q | ~ring_ok;
        err_cnt_d = err_cnt_q;
        if (!ring_ok && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            pending_q    <= 1'b0;
            stage_dig_q  <= 16'h0000;
            stage_dp_q   <= 4'h0;
            shadow_dig_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            an_q         <= 4'hF;
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            load_ack_q   <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            stage_dig_q  <= stage_dig_d;
            stage_dp_q   <= stage_dp_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            load_ack_q   <= load_ack_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp_n      = dp_n_q;
    assign load_ack  = load_ack_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (default parameters).
// Directed scenarios followed by randomized ring/load traffic, all checked
// every cycle against a behavioural model of the display rules.
module tb_seg7_scan_driver;
    import seg7_scan_pkg::*;

    localparam bit M_LZ  = 1'b1;
    localparam bit M_HEX = 1'b0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ring_in = 4'h0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        err;
    logic [7:0]  err_count;

    always #5 clock = ~clock;

    seg7_scan_driver #(.LZ_BLANK(M_LZ), .HEX_MODE(M_HEX)) dut (
        .clock(clock), .reset(reset), .ring_in(ring_in), .digits_in(digits_in),
        .dp_in(dp_in), .load(load), .load_ack(load_ack), .an(an), .seg(seg),
        .dp_n(dp_n), .err(err), .err_count(err_count)
    );

    // Active-high segment patterns (gfedcba, 1 = lit) for 0-9, A-F.
    logic [6:0] lit_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: mode 0 = waiting for sync, 1 = scanning, 2 = faulted.
    int          m_mode;
    logic        m_pend;
    logic [15:0] m_stg, m_shd;
    logic [3:0]  m_stgdp, m_shddp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn, e_ack, e_err;
    int          e_cnt;

    int ntests = 0;
    int nfail  = 0;
    int rp     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] model_glyph(input int v);
        if (v > 9 && !M_HEX) return 7'h7F;
        return ~lit_tab[v];
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] ring, input logic ld,
                              input logic [15:0] dig, input logic [3:0] dp);
        bit legal, xfer, blank;
        int nxt, k, v;
        if (rst) begin
            m_mode = 0; m_pend = 0; m_stg = 0; m_shd = 0; m_stgdp = 0; m_shddp = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1; e_ack = 0; e_err = 0; e_cnt = 0;
            return;
        end
        legal = ($countones(ring) == 1);
        xfer  = m_pend && m_mode != 2 && ring == 4'b0001;
        if (xfer) begin m_shd = m_stg; m_shddp = m_stgdp; end
        if (ld) begin m_stg = dig; m_stgdp = dp; m_pend = 1; end
        else if (xfer) m_pend = 0;
        if (m_mode == 0)      nxt = (ring == 4'b0001) ? 1 : 0;
        else if (m_mode == 1) nxt = legal ? 1 : 2;
        else                  nxt = (ring == 4'b0001) ? 0 : 2;
        m_mode = nxt;
        if (m_mode == 1) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (ring[i]) k = i;
            v = int'((m_shd >> (4 * k)) & 16'hF);
            // A digit is a leading zero when it and every digit above it are 0.
            blank = M_LZ && k > 0 && ((m_shd >> (4 * k)) == 16'h0);
            e_an  = ~ring;
            e_seg = blank ? 7'h7F : model_glyph(v);
            e_dpn = ~m_shddp[k];
        end else begin
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1;
        end
        e_ack = xfer;
        if (!legal) begin
            e_err = 1;
            if (e_cnt < 255) e_cnt++;
        end
    endtask

    task automatic cyc(input logic rst, input logic [3:0] ring, input logic ld,
                       input logic [15:0] dig, input logic [3:0] dp);
        state_t exp_st;
        reset = rst; ring_in = ring; load = ld; digits_in = dig; dp_in = dp;
        @(posedge clock);
        model_step(rst, ring, ld, dig, dp);
        #1;
        exp_st = (m_mode == 0) ? ST_SYNC : (m_mode == 1) ? ST_RUN : ST_FAULT;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("dp_n", dp_n, e_dpn);
        chk("load_ack", load_ack, e_ack);
        chk("err", err, e_err);
        chk("err_count", err_count, e_cnt);
        chk("state", dut.state_q, exp_st);
    endtask

    task automatic adv(input logic ld, input logic [15:0] dig, input logic [3:0] dp);
        cyc(1'b0, 4'(1 << rp), ld, dig, dp);
        rp = (rp + 1) % 4;
    endtask

    initial begin
        // Reset wins over a coincident load and an illegal ring value.
        cyc(1, 4'b0011, 1, 16'hFFFF, 4'hF);
        cyc(1, 4'b0000, 1, 16'hFFFF, 4'hF);
        chk("rst_an", an, 4'hF);
        chk("rst_cnt", err_count, 0);

        // Stage 1234, first 0001 transfers it and shows digit0.
        cyc(0, 4'b0010, 1, 16'h1234, 4'h0);
        rp = 0;
        adv(0, 0, 0);
        chk("first_an", an, 4'b1110);
        chk("first_seg4", seg, 7'b0011001);
        chk("first_ack", load_ack, 1);
        adv(0, 0, 0);
        chk("second_an", an, 4'b1101);
        chk("second_seg3", seg, 7'b0110000);
        repeat (10) adv(0, 0, 0);

        // Mid-frame load of 0042 with dp on the two blanked digits.
        adv(0, 0, 0); adv(0, 0, 0);
        adv(1, 16'h0042, 4'b1100);
        adv(0, 0, 0);
        adv(0, 0, 0);
        chk("lz_ack", load_ack, 1);
        chk("lz_d0", seg, 7'h24);
        adv(0, 0, 0);
        chk("lz_d1", seg, 7'h19);
        adv(0, 0, 0);
        chk("lz_d2_an", an, 4'b1011);
        chk("lz_d2_seg", seg, 7'h7F);
        adv(0, 0, 0);
        chk("lz_d3_seg", seg, 7'h7F);
        chk("lz_d3_dp", dp_n, 0);

        // Single glitch during RUN.
        adv(0, 0, 0); adv(0, 0, 0);
        cyc(0, 4'b0011, 0, 0, 0);
        chk("glitch_an", an, 4'hF);
        chk("glitch_err", err, 1);
        chk("glitch_cnt", err_count, 1);
        chk("glitch_state", dut.state_q, ST_FAULT);
        rp = 2;
        repeat (6) adv(0, 0, 0);
        chk("resync_blank", an, 4'hF);
        adv(0, 0, 0);
        chk("resync_run", an, 4'b1110);

        // Long all-zero ring: counter saturates.
        repeat (300) cyc(0, 4'b0000, 0, 0, 0);
        chk("sat_cnt", err_count, 8'hFF);
        chk("sat_err", err, 1);
        rp = 0;
        repeat (8) adv(0, 0, 0);

        // Load coincident with a pending transfer.
        adv(0, 0, 0); adv(0, 0, 0);
        adv(1, 16'h5678, 4'h0);
        adv(0, 0, 0);
        adv(1, 16'h0009, 4'h0);
        chk("coinc_ack1", load_ack, 1);
        chk("coinc_old", seg, 7'h00);
        repeat (3) adv(0, 0, 0);
        adv(0, 0, 0);
        chk("coinc_ack2", load_ack, 1);
        chk("coinc_new", seg, 7'h10);

        // Reset during RUN with a transfer pending.
        adv(0, 0, 0); adv(1, 16'h7777, 4'hF); adv(0, 0, 0);
        cyc(1, 4'b0001, 0, 0, 0);
        chk("rst_run_ack", load_ack, 0);
        chk("rst_run_an", an, 4'hF);
        cyc(0, 4'b0001, 0, 0, 0);
        chk("rst_run_noack", load_ack, 0);
        rp = 1;

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1) begin
                cyc(1, 4'($urandom), $urandom_range(0, 1), 16'($urandom), 4'($urandom));
                rp = 0;
            end else if (r < 4) begin
                cyc(0, 4'($urandom), $urandom_range(0, 1), 16'($urandom), 4'($urandom));
                rp = $urandom_range(0, 3);
            end else if (r < 14) begin
                adv(1, (r < 8) ? 16'($urandom_range(0, 255)) : 16'($urandom), 4'($urandom));
            end else begin
                adv(0, 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
